ycr_memif_wb_bridge: RTL and testbench
======================================

# ycr_memif_wb_bridge

Downstream stage of the core cross-bar. Converts one cross-bar output port (e.g. the dmem port) from the ycr memory-request interface into a classic/registered-burst Wishbone B4 master. Supports single reads/writes and incrementing read bursts, and returns per-beat responses with last-beat (LOK) marking so the cross-bar can release its target lock. A timeout counter guarantees every accepted request terminates.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width (fixed 4 byte lanes)
- BLW, 3, burst-length field width
- TIMEOUT, 255, max wait cycles for wbm_ack/err per beat; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- mem_req  in  1  request valid
- mem_req_ack  out  1  request accepted (combinational)
- mem_cmd  in  1  0 read, 1 write
- mem_width  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_addr  in  AW  byte address
- mem_bl  in  BLW  beat count; 0 treated as 1
- mem_wdata  in  DW  write data, lane-replicated by the requester
- mem_rdata  out  DW  read data, raw 32-bit word
- mem_resp  out  2  00 not ready, 01 beat ok, 10 error, 11 last beat ok (LOK)
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone cycle/strobe/write
- wbm_adr_o  out  AW  word-aligned address
- wbm_sel_o  out  4  byte enables
- wbm_dat_o  out  DW  write data
- wbm_cti_o  out  3  000 classic, 010 incrementing, 111 end-of-burst
- wbm_dat_i  in  DW  read data
- wbm_ack_i, wbm_err_i  in  1  beat terminate ok/error

## Operation
- FSM states IDLE, BUSY.
- IDLE: mem_req_ack = mem_req. On mem_req && mem_req_ack capture cmd, width, addr, bl (0→1; forced to 1 when cmd=write), wdata; clear beat counter and timeout counter; go BUSY.
- BUSY: mem_req_ack = 0. wbm_cyc_o = wbm_stb_o = 1; wbm_we_o = captured cmd; wbm_adr_o = {addr[AW-1:2],2'b00} + 4*beat, modulo 2^AW.
- wbm_sel_o for single-beat: byte → 4'b0001<<addr[1:0]; half → 4'b0011<<{addr[1],1'b0} (addr[0] ignored); word/11 → 4'hF. Burst beats: 4'hF.
- wbm_cti_o: 000 when bl=1; 010 on non-last burst beats; 111 on last burst beat.
- wbm_ack_i on non-last beat: beat++, timeout counter cleared, stay BUSY, cyc/stb stay high.
- wbm_ack_i on last beat: drop cyc/stb next cycle, go IDLE.
- wbm_err_i (priority over ack if both high): terminate whole transaction, go IDLE; no further beats issued.
- Timeout: counter increments each BUSY cycle without ack/err; on reaching TIMEOUT, treat as err (resp 10), go IDLE.
- Write: mem_rdata unchanged; response uses same encoding.

## Timing
- Reset: state IDLE, all wbm_* outputs 0, mem_resp 00, mem_rdata 0, counters 0. mem_req_ack = mem_req after reset release.
- Acceptance cycle N → wbm_cyc_o/stb_o high from N+1.
- wbm_ack_i at cycle M → mem_rdata = wbm_dat_i (reads), mem_resp = 01 (non-last) or 11 (last) at M+1, single-cycle pulse; otherwise mem_resp = 00.
- wbm_err_i or timeout at M → mem_resp = 10 at M+1, one cycle; mem_rdata holds previous value.
- Back-to-back: FSM is IDLE at M+1, so a new request can be accepted in the same cycle LOK/err is presented; its cyc/stb rise at M+2.
- Minimum single-access latency (ack same cycle as stb): accept N, ack N+1, resp N+2.
- Reset asserted mid-burst: all outputs clear immediately (async), no response issued.

## Test plan
- Single word read, addr 0x1000_0004, slave acks 2 cycles after stb: wbm_adr_o 0x1000_0004, sel F, cti 000; mem_resp 11 with rdata = slave data one cycle after ack; mem_req_ack low during BUSY.
- Byte write to 0x20 | 3, data 0xAABBCCDD: sel 4'b1000, we 1, adr 0x20, dat_o 0xAABBCCDD; resp 11 once; halfword write to 0x22 → sel 4'b1100.
- Read burst bl=4 at 0xFFFF_FFF8: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004; cti 010,010,010,111; resp 01,01,01,11.
- wbm_err_i on beat 2 of bl=4 burst: resp 01 then 10; cyc drops; no beats 3–4; next request accepted.
- No ack with TIMEOUT=8: resp 10 exactly 9 cycles after stb rise; TIMEOUT=0 waits indefinitely.
- Back-to-back requests with zero-wait slave; and rst_n pulsed mid-burst: all outputs 0 immediately, clean restart.

Source files
------------

// File: rtl/ycr_memif_wb_bridge_if.sv
// Bus bundles for the ycr memory-request port and the Wishbone B4 master port.
// master = side that initiates requests on that bus, slave = side that answers them.
interface ycr_mem_if #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int BLW = 3
) ();
    logic           mem_req;
    logic           mem_req_ack;
    logic           mem_cmd;
    logic [1:0]     mem_width;
    logic [AW-1:0]  mem_addr;
    logic [BLW-1:0] mem_bl;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata;
    logic [1:0]     mem_resp;

    modport master (
        output mem_req, mem_cmd, mem_width, mem_addr, mem_bl, mem_wdata,
        input  mem_req_ack, mem_rdata, mem_resp
    );
    modport slave (
        input  mem_req, mem_cmd, mem_width, mem_addr, mem_bl, mem_wdata,
        output mem_req_ack, mem_rdata, mem_resp
    );
endinterface

interface ycr_wb_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic          wbm_we_o;
    logic [AW-1:0] wbm_adr_o;
    logic [3:0]    wbm_sel_o;
    logic [DW-1:0] wbm_dat_o;
    logic [2:0]    wbm_cti_o;
    logic [DW-1:0] wbm_dat_i;
    logic          wbm_ack_i;
    logic          wbm_err_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o, wbm_cti_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );
    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o, wbm_cti_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/ycr_memif_wb_bridge.sv
// ycr memory-request to Wishbone B4 master (single + incrementing read bursts); cyc/stb one cycle after accept,
// response one cycle after ack/err/timeout; one request in flight, mem_req_ack held low while BUSY.
module ycr_memif_wb_bridge #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int BLW     = 3,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    ycr_mem_if.slave    mem,
    ycr_wb_if.master    wbm
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q, state_d;
    logic           cmd_q;
    logic [1:0]     width_q;
    logic [AW-1:0]  addr_q;
    logic [BLW-1:0] bl_q;
    logic [BLW-1:0] beat_q;
    logic [DW-1:0]  wdata_q;
    logic [TW-1:0]  tcnt_q;
    logic [1:0]     resp_q, resp_d;
    logic [DW-1:0]  rdata_q;

    logic           busy;
    logic           accept;
    logic           beat_ok;
    logic           rdata_ld;
    logic           last_beat;
    logic           timeout_hit;
    logic [BLW-1:0] bl_in;
    logic [3:0]     sel_single;

    assign busy      = (state_q == BUSY);
    assign last_beat = (beat_q == bl_q - BLW'(1));
    // Writes are always single-beat; a zero length still means one beat.
    assign bl_in     = (mem.mem_cmd || (mem.mem_bl == '0)) ? BLW'(1) : mem.mem_bl;
    assign timeout_hit = (TIMEOUT != 0) && (tcnt_q == TW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        beat_ok  = 1'b0;
        rdata_ld = 1'b0;
        resp_d   = 2'b00;
        case (state_q)
            IDLE: begin
                if (mem.mem_req) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // err beats ack; a timeout only fires when the slave stays silent
                if (wbm.wbm_err_i || (timeout_hit && !wbm.wbm_ack_i)) begin
                    resp_d  = 2'b10;
                    state_d = IDLE;
                end else if (wbm.wbm_ack_i) begin
                    beat_ok  = 1'b1;
                    rdata_ld = !cmd_q;
                    resp_d   = last_beat ? 2'b11 : 2'b01;
                    if (last_beat) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q   <= 1'b0;
            width_q <= 2'b00;
            addr_q  <= '0;
            bl_q    <= BLW'(1);
            wdata_q <= '0;
        end else if (accept) begin
            cmd_q   <= mem.mem_cmd;
            width_q <= mem.mem_width;
            addr_q  <= mem.mem_addr;
            bl_q    <= bl_in;
            wdata_q <= mem.mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
            tcnt_q <= '0;
        end else if (accept) begin
            beat_q <= '0;
            tcnt_q <= '0;
        end else if (beat_ok) begin
            beat_q <= beat_q + BLW'(1);
            tcnt_q <= '0;
        end else if (busy && (TIMEOUT != 0) && !timeout_hit) begin
            tcnt_q <= tcnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q  <= 2'b00;
            rdata_q <= '0;
        end else begin
            resp_q <= resp_d;
            if (rdata_ld) rdata_q <= wbm.wbm_dat_i;
        end
    end

    always_comb begin
        sel_single = 4'hF;
        case (width_q)
            2'b00:   sel_single = 4'b0001 << addr_q[1:0];
            2'b01:   sel_single = 4'b0011 << {addr_q[1], 1'b0};
            default: sel_single = 4'hF;
        endcase
    end

    assign mem.mem_req_ack = (state_q == IDLE) && mem.mem_req;
    assign mem.mem_resp    = resp_q;
    assign mem.mem_rdata   = rdata_q;

    assign wbm.wbm_cyc_o = busy;
    assign wbm.wbm_stb_o = busy;
    assign wbm.wbm_we_o  = busy && cmd_q;
    assign wbm.wbm_adr_o = busy ? ({addr_q[AW-1:2], 2'b00} + (AW'(beat_q) << 2)) : '0;
    assign wbm.wbm_sel_o = !busy ? 4'h0 : ((bl_q == BLW'(1)) ? sel_single : 4'hF);
    assign wbm.wbm_dat_o = busy ? wdata_q : '0;
    assign wbm.wbm_cti_o = (!busy || (bl_q == BLW'(1))) ? 3'b000 :
                           (last_beat ? 3'b111 : 3'b010);

endmodule

// File: tb/tb_ycr_memif_wb_bridge.sv
// Directed bench: u0 runs with TIMEOUT=8, u1 with TIMEOUT=0 for the wait-forever case.
module tb_ycr_memif_wb_bridge;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ycr_mem_if #(.AW(32), .DW(32), .BLW(3)) mi0 ();
    ycr_wb_if  #(.AW(32), .DW(32))          wi0 ();
    ycr_mem_if #(.AW(32), .DW(32), .BLW(3)) mi1 ();
    ycr_wb_if  #(.AW(32), .DW(32))          wi1 ();

    ycr_memif_wb_bridge #(.AW(32), .DW(32), .BLW(3), .TIMEOUT(8)) u0 (
        .clk(clk), .rst_n(rst_n), .mem(mi0), .wbm(wi0));
    ycr_memif_wb_bridge #(.AW(32), .DW(32), .BLW(3), .TIMEOUT(0)) u1 (
        .clk(clk), .rst_n(rst_n), .mem(mi1), .wbm(wi1));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic cmd, input logic [1:0] w, input logic [31:0] a,
                             input logic [2:0] bl, input logic [31:0] wd);
        mi0.mem_req   = 1'b1;
        mi0.mem_cmd   = cmd;
        mi0.mem_width = w;
        mi0.mem_addr  = a;
        mi0.mem_bl    = bl;
        mi0.mem_wdata = wd;
    endtask

    task automatic test_reset;
        #1;
        n_cmp++; if (wi0.wbm_cyc_o !== 1'b0) begin n_bad++; $display("FAIL rst_cyc: got %b want 0", wi0.wbm_cyc_o); end
        n_cmp++; if (wi0.wbm_stb_o !== 1'b0) begin n_bad++; $display("FAIL rst_stb: got %b want 0", wi0.wbm_stb_o); end
        n_cmp++; if (wi0.wbm_adr_o !== 32'h0) begin n_bad++; $display("FAIL rst_adr: got %h want 0", wi0.wbm_adr_o); end
        n_cmp++; if (wi0.wbm_sel_o !== 4'h0) begin n_bad++; $display("FAIL rst_sel: got %h want 0", wi0.wbm_sel_o); end
        n_cmp++; if (wi0.wbm_cti_o !== 3'b000) begin n_bad++; $display("FAIL rst_cti: got %b want 000", wi0.wbm_cti_o); end
        n_cmp++; if (mi0.mem_resp !== 2'b00) begin n_bad++; $display("FAIL rst_resp: got %b want 00", mi0.mem_resp); end
        n_cmp++; if (mi0.mem_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", mi0.mem_rdata); end
        tick;
        tick;
        rst_n = 1'b1;
        mi0.mem_req = 1'b1;
        #1;
        n_cmp++; if (mi0.mem_req_ack !== 1'b1) begin n_bad++; $display("FAIL rst_reqack_hi: got %b want 1", mi0.mem_req_ack); end
        mi0.mem_req = 1'b0;
        #1;
        n_cmp++; if (mi0.mem_req_ack !== 1'b0) begin n_bad++; $display("FAIL rst_reqack_lo: got %b want 0", mi0.mem_req_ack); end
        tick;
        n_cmp++; if (wi0.wbm_cyc_o !== 1'b0) begin n_bad++; $display("FAIL rst_idle_cyc: got %b want 0", wi0.wbm_cyc_o); end
    endtask

    task automatic test_single_read;
        tick;
        drive_req(1'b0, 2'b10, 32'h1000_0004, 3'd0, 32'h0);
        #1;
        n_cmp++; if (mi0.mem_req_ack !== 1'b1) begin n_bad++; $display("FAIL rd_reqack: got %b want 1", mi0.mem_req_ack); end
        tick;
        #1;
        n_cmp++; if (mi0.mem_req_ack !== 1'b0) begin n_bad++; $display("FAIL rd_reqack_busy: got %b want 0", mi0.mem_req_ack); end
        n_cmp++; if ({wi0.wbm_cyc_o, wi0.wbm_stb_o, wi0.wbm_we_o} !== 3'b110) begin n_bad++; $display("FAIL rd_cyc_stb_we: got %b want 110", {wi0.wbm_cyc_o, wi0.wbm_stb_o, wi0.wbm_we_o}); end
        n_cmp++; if (wi0.wbm_adr_o !== 32'h1000_0004) begin n_bad++; $display("FAIL rd_adr: got %h want 10000004", wi0.wbm_adr_o); end
        n_cmp++; if (wi0.wbm_sel_o !== 4'hF) begin n_bad++; $display("FAIL rd_sel: got %h want f", wi0.wbm_sel_o); end
        n_cmp++; if (wi0.wbm_cti_o !== 3'b000) begin n_bad++; $display("FAIL rd_cti: got %b want 000", wi0.wbm_cti_o); end
        mi0.mem_req = 1'b0;
        tick;
        n_cmp++; if (mi0.mem_resp !== 2'b00 || wi0.wbm_cyc_o !== 1'b1) begin n_bad++; $display("FAIL rd_wait: got resp %b cyc %b want 00 1", mi0.mem_resp, wi0.wbm_cyc_o); end
        tick;
        wi0.wbm_ack_i = 1'b1;
        wi0.wbm_dat_i = 32'hCAFE_BABE;
        tick;
        wi0.wbm_ack_i = 1'b0;
        n_cmp++; if (mi0.mem_resp !== 2'b11) begin n_bad++; $display("FAIL rd_resp: got %b want 11", mi0.mem_resp); end
        n_cmp++; if (mi0.mem_rdata !== 32'hCAFE_BABE) begin n_bad++; $display("FAIL rd_rdata: got %h want cafebabe", mi0.mem_rdata); end
        n_cmp++; if (wi0.wbm_cyc_o !== 1'b0) begin n_bad++; $display("FAIL rd_cyc_drop: got %b want 0", wi0.wbm_cyc_o); end
        tick;
        n_cmp++; if (mi0.mem_resp !== 2'b00) begin n_bad++; $display("FAIL rd_resp_pulse: got %b want 00", mi0.mem_resp); end
    endtask

    task automatic test_byte_write;
        tick;
        drive_req(1'b1, 2'b00, 32'h0000_0023, 3'd3, 32'hAABB_CCDD);
        tick;
        mi0.mem_req = 1'b0;
        n_cmp++; if (wi0.wbm_we_o !== 1'b1) begin n_bad++; $display("FAIL bw_we: got %b want 1", wi0.wbm_we_o); end
        n_cmp++; if (wi0.wbm_sel_o !== 4'b1000) begin n_bad++; $display("FAIL bw_sel: got %b want 1000", wi0.wbm_sel_o); end
        n_cmp++; if (wi0.wbm_adr_o !== 32'h20) begin n_bad++; $display("FAIL bw_adr: got %h want 20", wi0.wbm_adr_o); end
        n_cmp++; if (wi0.wbm_dat_o !== 32'hAABB_CCDD) begin n_bad++; $display("FAIL bw_dat: got %h want aabbccdd", wi0.wbm_dat_o); end
        n_cmp++; if (wi0.wbm_cti_o !== 3'b000) begin n_bad++; $display("FAIL bw_cti: got %b want 000", wi0.wbm_cti_o); end
        wi0.wbm_ack_i = 1'b1;
        wi0.wbm_dat_i = 32'h1234_5678;
        tick;
        wi0.wbm_ack_i = 1'b0;
        n_cmp++; if (mi0.mem_resp !== 2'b11) begin n_bad++; $display("FAIL bw_resp: got %b want 11", mi0.mem_resp); end
        n_cmp++; if (mi0.mem_rdata !== 32'hCAFE_BABE) begin n_bad++; $display("FAIL bw_rdata_hold: got %h want cafebabe", mi0.mem_rdata); end
        n_cmp++; if (wi0.wbm_cyc_o !== 1'b0) begin n_bad++; $display("FAIL bw_cyc_drop: got %b want 0", wi0.wbm_cyc_o); end
        tick;
        n_cmp++; if (mi0.mem_resp !== 2'b00) begin n_bad++; $display("FAIL bw_resp_once: got %b want 00", mi0.mem_resp); end
    endtask

    task automatic test_half_write;
        tick;
        drive_req(1'b1, 2'b01, 32'h0000_0022, 3'd1, 32'h5566_5566);
        tick;
        mi0.mem_req = 1'b0;
        n_cmp++; if (wi0.wbm_sel_o !== 4'b1100) begin n_bad++; $display("FAIL hw_sel: got %b want 1100", wi0.wbm_sel_o); end
        n_cmp++; if (wi0.wbm_adr_o !== 32'h20) begin n_bad++; $display("FAIL hw_adr: got %h want 20", wi0.wbm_adr_o); end
        wi0.wbm_ack_i = 1'b1;
        tick;
        wi0.wbm_ack_i = 1'b0;
        n_cmp++; if (mi0.mem_resp !== 2'b11) begin n_bad++; $display("FAIL hw_resp: got %b want 11", mi0.mem_resp); end
    endtask

    task automatic test_read_burst;
        logic [31:0] exp_adr [4];
        logic [2:0]  exp_cti [4];
        exp_adr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        exp_cti = '{3'b010, 3'b010, 3'b010, 3'b111};
        tick;
        drive_req(1'b0, 2'b10, 32'hFFFF_FFF8, 3'd4, 32'h0);
        tick;
        mi0.mem_req = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (b > 0) begin
                tick;
                n_cmp++; if (mi0.mem_resp !== 2'b01) begin n_bad++; $display("FAIL bst_resp%0d: got %b want 01", b - 1, mi0.mem_resp); end
                n_cmp++; if (mi0.mem_rdata !== 32'h100 + 32'(b - 1)) begin n_bad++; $display("FAIL bst_rdata%0d: got %h want %h", b - 1, mi0.mem_rdata, 32'h100 + 32'(b - 1)); end
            end
            n_cmp++; if (wi0.wbm_adr_o !== exp_adr[b]) begin n_bad++; $display("FAIL bst_adr%0d: got %h want %h", b, wi0.wbm_adr_o, exp_adr[b]); end
            n_cmp++; if (wi0.wbm_cti_o !== exp_cti[b]) begin n_bad++; $display("FAIL bst_cti%0d: got %b want %b", b, wi0.wbm_cti_o, exp_cti[b]); end
            n_cmp++; if (wi0.wbm_sel_o !== 4'hF) begin n_bad++; $display("FAIL bst_sel%0d: got %h want f", b, wi0.wbm_sel_o); end
            wi0.wbm_ack_i = 1'b1;
            wi0.wbm_dat_i = 32'h100 + 32'(b);
        end
        tick;
        wi0.wbm_ack_i = 1'b0;
        n_cmp++; if (mi0.mem_resp !== 2'b11) begin n_bad++; $display("FAIL bst_lok: got %b want 11", mi0.mem_resp); end
        n_cmp++; if (mi0.mem_rdata !== 32'h103) begin n_bad++; $display("FAIL bst_rdata3: got %h want 103", mi0.mem_rdata); end
        n_cmp++; if (wi0.wbm_cyc_o !== 1'b0) begin n_bad++; $display("FAIL bst_cyc_drop: got %b want 0", wi0.wbm_cyc_o); end
    endtask

    task automatic test_err_burst;
        tick;
        drive_req(1'b0, 2'b10, 32'h0000_0040, 3'd4, 32'h0);
        tick;
        mi0.mem_req = 1'b0;
        wi0.wbm_ack_i = 1'b1;
        wi0.wbm_dat_i = 32'h55;
        tick;
        wi0.wbm_ack_i = 1'b0;
        wi0.wbm_err_i = 1'b1;
        n_cmp++; if (mi0.mem_resp !== 2'b01) begin n_bad++; $display("FAIL err_resp0: got %b want 01", mi0.mem_resp); end
        n_cmp++; if (wi0.wbm_adr_o !== 32'h44) begin n_bad++; $display("FAIL err_adr1: got %h want 44", wi0.wbm_adr_o); end
        n_cmp++; if (wi0.wbm_cti_o !== 3'b010) begin n_bad++; $display("FAIL err_cti1: got %b want 010", wi0.wbm_cti_o); end
        tick;
        wi0.wbm_err_i = 1'b0;
        n_cmp++; if (mi0.mem_resp !== 2'b10) begin n_bad++; $display("FAIL err_resp: got %b want 10", mi0.mem_resp); end
        n_cmp++; if (wi0.wbm_cyc_o !== 1'b0) begin n_bad++; $display("FAIL err_cyc_drop: got %b want 0", wi0.wbm_cyc_o); end
        n_cmp++; if (mi0.mem_rdata !== 32'h55) begin n_bad++; $display("FAIL err_rdata_hold: got %h want 55", mi0.mem_rdata); end
        drive_req(1'b0, 2'b10, 32'h0000_0060, 3'd0, 32'h0);
        #1;
        n_cmp++; if (mi0.mem_req_ack !== 1'b1) begin n_bad++; $display("FAIL err_next_ack: got %b want 1", mi0.mem_req_ack); end
        tick;
        mi0.mem_req = 1'b0;
        n_cmp++; if (wi0.wbm_adr_o !== 32'h60 || wi0.wbm_cyc_o !== 1'b1) begin n_bad++; $display("FAIL err_next_adr: got %h/%b want 60/1", wi0.wbm_adr_o, wi0.wbm_cyc_o); end
        wi0.wbm_ack_i = 1'b1;
        wi0.wbm_dat_i = 32'h66;
        tick;
        wi0.wbm_ack_i = 1'b0;
        n_cmp++; if (mi0.mem_resp !== 2'b11 || mi0.mem_rdata !== 32'h66) begin n_bad++; $display("FAIL err_next_resp: got %b/%h want 11/66", mi0.mem_resp, mi0.mem_rdata); end
    endtask

    task automatic test_timeout;
        tick;
        drive_req(1'b0, 2'b10, 32'h0000_0080, 3'd0, 32'h0);
        tick;
        mi0.mem_req = 1'b0;
        n_cmp++; if (wi0.wbm_cyc_o !== 1'b1) begin n_bad++; $display("FAIL to_stb_rise: got %b want 1", wi0.wbm_cyc_o); end
        for (int k = 1; k <= 8; k++) begin
            tick;
            n_cmp++; if (mi0.mem_resp !== 2'b00 || wi0.wbm_cyc_o !== 1'b1) begin n_bad++; $display("FAIL to_wait%0d: got resp %b cyc %b want 00 1", k, mi0.mem_resp, wi0.wbm_cyc_o); end
        end
        tick;
        n_cmp++; if (mi0.mem_resp !== 2'b10) begin n_bad++; $display("FAIL to_resp: got %b want 10", mi0.mem_resp); end
        n_cmp++; if (wi0.wbm_cyc_o !== 1'b0) begin n_bad++; $display("FAIL to_cyc_drop: got %b want 0", wi0.wbm_cyc_o); end
        tick;
        n_cmp++; if (mi0.mem_resp !== 2'b00) begin n_bad++; $display("FAIL to_resp_pulse: got %b want 00", mi0.mem_resp); end
    endtask

    task automatic test_no_timeout;
        int busy_cycles;
        busy_cycles = 0;
        tick;
        mi1.mem_req   = 1'b1;
        mi1.mem_cmd   = 1'b0;
        mi1.mem_width = 2'b10;
        mi1.mem_addr  = 32'h0000_0500;
        mi1.mem_bl    = 3'd1;
        mi1.mem_wdata = 32'h0;
        tick;
        mi1.mem_req = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (wi1.wbm_cyc_o === 1'b1 && mi1.mem_resp === 2'b00) busy_cycles++;
            tick;
        end
        n_cmp++; if (busy_cycles !== 300) begin n_bad++; $display("FAIL nto_wait: got %0d busy cycles want 300", busy_cycles); end
        wi1.wbm_ack_i = 1'b1;
        wi1.wbm_dat_i = 32'h77;
        tick;
        wi1.wbm_ack_i = 1'b0;
        n_cmp++; if (mi1.mem_resp !== 2'b11 || mi1.mem_rdata !== 32'h77) begin n_bad++; $display("FAIL nto_resp: got %b/%h want 11/77", mi1.mem_resp, mi1.mem_rdata); end
    endtask

    task automatic test_back_to_back;
        tick;
        drive_req(1'b0, 2'b10, 32'h0000_0100, 3'd0, 32'h0);
        tick;
        mi0.mem_addr = 32'h0000_0200;
        #1;
        n_cmp++; if (mi0.mem_req_ack !== 1'b0) begin n_bad++; $display("FAIL b2b_ack_busy: got %b want 0", mi0.mem_req_ack); end
        wi0.wbm_ack_i = 1'b1;
        wi0.wbm_dat_i = 32'h11;
        tick;
        wi0.wbm_ack_i = 1'b0;
        n_cmp++; if (mi0.mem_resp !== 2'b11 || mi0.mem_rdata !== 32'h11) begin n_bad++; $display("FAIL b2b_resp1: got %b/%h want 11/11", mi0.mem_resp, mi0.mem_rdata); end
        n_cmp++; if (wi0.wbm_cyc_o !== 1'b0) begin n_bad++; $display("FAIL b2b_gap: got %b want 0", wi0.wbm_cyc_o); end
        #1;
        n_cmp++; if (mi0.mem_req_ack !== 1'b1) begin n_bad++; $display("FAIL b2b_ack2: got %b want 1", mi0.mem_req_ack); end
        tick;
        mi0.mem_req = 1'b0;
        n_cmp++; if (wi0.wbm_cyc_o !== 1'b1 || wi0.wbm_adr_o !== 32'h200) begin n_bad++; $display("FAIL b2b_adr2: got %b/%h want 1/200", wi0.wbm_cyc_o, wi0.wbm_adr_o); end
        wi0.wbm_ack_i = 1'b1;
        wi0.wbm_dat_i = 32'h22;
        tick;
        wi0.wbm_ack_i = 1'b0;
        n_cmp++; if (mi0.mem_resp !== 2'b11 || mi0.mem_rdata !== 32'h22) begin n_bad++; $display("FAIL b2b_resp2: got %b/%h want 11/22", mi0.mem_resp, mi0.mem_rdata); end
    endtask

    task automatic test_reset_midburst;
        tick;
        drive_req(1'b0, 2'b10, 32'h0000_0300, 3'd4, 32'h0);
        tick;
        mi0.mem_req = 1'b0;
        wi0.wbm_ack_i = 1'b1;
        wi0.wbm_dat_i = 32'h33;
        tick;
        wi0.wbm_ack_i = 1'b0;
        n_cmp++; if (mi0.mem_resp !== 2'b01) begin n_bad++; $display("FAIL mrst_pre_resp: got %b want 01", mi0.mem_resp); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({wi0.wbm_cyc_o, wi0.wbm_stb_o, wi0.wbm_we_o} !== 3'b000) begin n_bad++; $display("FAIL mrst_cyc: got %b want 000", {wi0.wbm_cyc_o, wi0.wbm_stb_o, wi0.wbm_we_o}); end
        n_cmp++; if (wi0.wbm_adr_o !== 32'h0 || wi0.wbm_sel_o !== 4'h0 || wi0.wbm_cti_o !== 3'b000) begin n_bad++; $display("FAIL mrst_bus: got adr %h sel %h cti %b want 0", wi0.wbm_adr_o, wi0.wbm_sel_o, wi0.wbm_cti_o); end
        n_cmp++; if (mi0.mem_resp !== 2'b00 || mi0.mem_rdata !== 32'h0) begin n_bad++; $display("FAIL mrst_mem: got %b/%h want 00/0", mi0.mem_resp, mi0.mem_rdata); end
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        n_cmp++; if (mi0.mem_resp !== 2'b00 || wi0.wbm_cyc_o !== 1'b0) begin n_bad++; $display("FAIL mrst_quiet: got %b/%b want 00/0", mi0.mem_resp, wi0.wbm_cyc_o); end
        drive_req(1'b0, 2'b10, 32'h0000_0400, 3'd0, 32'h0);
        tick;
        mi0.mem_req = 1'b0;
        n_cmp++; if (wi0.wbm_cyc_o !== 1'b1 || wi0.wbm_adr_o !== 32'h400 || wi0.wbm_cti_o !== 3'b000) begin n_bad++; $display("FAIL mrst_restart: got %b/%h/%b want 1/400/000", wi0.wbm_cyc_o, wi0.wbm_adr_o, wi0.wbm_cti_o); end
        wi0.wbm_ack_i = 1'b1;
        wi0.wbm_dat_i = 32'h44;
        tick;
        wi0.wbm_ack_i = 1'b0;
        n_cmp++; if (mi0.mem_resp !== 2'b11 || mi0.mem_rdata !== 32'h44) begin n_bad++; $display("FAIL mrst_resp: got %b/%h want 11/44", mi0.mem_resp, mi0.mem_rdata); end
    endtask

    initial begin
        mi0.mem_req = 1'b0; mi0.mem_cmd = 1'b0; mi0.mem_width = 2'b10;
        mi0.mem_addr = '0; mi0.mem_bl = '0; mi0.mem_wdata = '0;
        wi0.wbm_dat_i = '0; wi0.wbm_ack_i = 1'b0; wi0.wbm_err_i = 1'b0;
        mi1.mem_req = 1'b0; mi1.mem_cmd = 1'b0; mi1.mem_width = 2'b10;
        mi1.mem_addr = '0; mi1.mem_bl = '0; mi1.mem_wdata = '0;
        wi1.wbm_dat_i = '0; wi1.wbm_ack_i = 1'b0; wi1.wbm_err_i = 1'b0;

        test_reset;
        test_single_read;
        test_byte_write;
        test_half_write;
        test_read_burst;
        test_err_burst;
        test_timeout;
        test_no_timeout;
        test_back_to_back;
        test_reset_midburst;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion before 200000");
        $fatal(1, "watchdog");
    end

endmodule
